// File: rtl/rom_fetch_unit.sv
// ---------------------------------------------------------------------------
// rom_fetch_unit
//
// Reader side of the 8051 program ROM. This block walks fetch_pc through the
// program ROM, which has a one-cycle registered read. It collects the returned
// bytes in a small prefetch queue. The decoder sees up to three head bytes.
// The decoder retires 0-3 bytes per cycle. A jump redirects fetch and flushes
// the queue.
//
// Parameters
//   DEPTH         prefetch queue depth in bytes (3..7; avail is 3 bits)
//   RESET_VECTOR  first fetch address after reset
//
// Ports
//   clock        in   system clock, all state updates on posedge
//   reset        in   synchronous, active-high
//   rom_addr     out  [15:0] address to the program ROM (equals fetch_pc)
//   rom_data     in   [7:0]  ROM byte for the address sampled at the last edge
//   consume      in   [1:0]  bytes the decoder retires this cycle
//   jump_en      in   redirect fetch this cycle
//   jump_addr    in   [15:0] redirect target
//   byte0..2     out  [7:0]  queue head .. head+2 (8'h00 when not valid)
//   avail        out  [2:0]  valid bytes in the queue
//   head_pc      out  [15:0] code address of byte0
//   consume_err  out  one-cycle pulse when consume exceeds avail
// ---------------------------------------------------------------------------
module rom_fetch_unit #(
    parameter int          DEPTH        = 4,
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic [1:0]  consume,
    input  logic        jump_en,
    input  logic [15:0] jump_addr,
    output logic [7:0]  byte0,
    output logic [7:0]  byte1,
    output logic [7:0]  byte2,
    output logic [2:0]  avail,
    output logic [15:0] head_pc,
    output logic        consume_err
);

    localparam int         QW      = 8 * DEPTH;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    // Control state
    logic [15:0] fetch_pc;
    logic [15:0] head_pc_q;
    logic [2:0]  avail_q;
    logic        inflight_p1;
    logic        consume_err_q;

    // Data state: entry 0 sits in the low byte.
    logic [QW-1:0] queue_q;
    logic [7:0]    byte0_q;
    logic [7:0]    byte1_q;
    logic [7:0]    byte2_q;

    // Next-state signals
    logic [3:0]    occupancy;
    logic          issue;
    logic          push;
    logic          consume_ok;
    logic [1:0]    pop;
    logic          err_next;
    logic [2:0]    tail;
    logic [2:0]    avail_next;
    logic [15:0]   fetch_pc_next;
    logic [15:0]   head_pc_next;
    logic [QW-1:0] queue_shift;
    logic [QW-1:0] lane_mask;
    logic [QW-1:0] lane_data;
    logic [QW-1:0] queue_next;
    logic [7:0]    byte0_next;
    logic [7:0]    byte1_next;
    logic [7:0]    byte2_next;

    assign rom_addr    = fetch_pc;
    assign avail       = avail_q;
    assign head_pc     = head_pc_q;
    assign consume_err = consume_err_q;
    assign byte0       = byte0_q;
    assign byte1       = byte1_q;
    assign byte2       = byte2_q;

    always_comb begin
        // Space is reserved for the byte in flight. A request is therefore
        // only made when the byte is guaranteed a slot on its return.
        occupancy  = {1'b0, avail_q} + {3'b000, inflight_p1};
        issue      = !jump_en && (occupancy < DEPTH_L);

        // A returning byte is dropped when a jump lands in the same cycle.
        // Otherwise it would belong to the old instruction stream.
        push       = inflight_p1 && !jump_en;

        consume_ok = ({1'b0, consume} <= avail_q);
        pop        = (!jump_en && consume_ok) ? consume : 2'd0;
        err_next   = !jump_en && !consume_ok;

        if (jump_en) begin
            avail_next = 3'd0;
        end else begin
            avail_next = avail_q - {1'b0, pop} + {2'b00, push};
        end

        if (jump_en) begin
            fetch_pc_next = jump_addr;
        end else if (issue) begin
            fetch_pc_next = fetch_pc + 16'd1;
        end else begin
            fetch_pc_next = fetch_pc;
        end

        if (jump_en) begin
            head_pc_next = jump_addr;
        end else begin
            head_pc_next = head_pc_q + {14'd0, pop};
        end

        // Retire from the head by shifting down. The incoming byte then
        // lands right behind the surviving entries. The tail index stays
        // below DEPTH because issue reserved the slot.
        queue_shift = queue_q >> {pop, 3'b000};
        tail        = avail_q - {1'b0, pop};
        lane_mask   = {{(QW-8){1'b0}}, 8'hFF} << {tail, 3'b000};
        lane_data   = {{(QW-8){1'b0}}, rom_data} << {tail, 3'b000};
        if (push) begin
            queue_next = (queue_shift & ~lane_mask) | lane_data;
        end else begin
            queue_next = queue_shift;
        end

        // The head bytes are registered from the post-update queue.
        // They are masked to zero past the valid count.
        byte0_next = (avail_next > 3'd0) ? queue_next[7:0]   : 8'h00;
        byte1_next = (avail_next > 3'd1) ? queue_next[15:8]  : 8'h00;
        byte2_next = (avail_next > 3'd2) ? queue_next[23:16] : 8'h00;
    end

    // Stage p0 -> p1: request issued, byte in flight in the ROM
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc      <= RESET_VECTOR;
            head_pc_q     <= RESET_VECTOR;
            avail_q       <= 3'd0;
            inflight_p1   <= 1'b0;
            consume_err_q <= 1'b0;
        end else begin
            fetch_pc      <= fetch_pc_next;
            head_pc_q     <= head_pc_next;
            avail_q       <= avail_next;
            inflight_p1   <= issue;
            consume_err_q <= err_next;
        end
    end

    // Stage p1 -> p2: returned byte captured into the queue
    always_ff @(posedge clock) begin
        queue_q <= queue_next;
    end

    // The head outputs have defined reset values for the decoder.
    // This is why they reset, unlike the queue storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte0_q <= 8'h00;
            byte1_q <= 8'h00;
            byte2_q <= 8'h00;
        end else begin
            byte0_q <= byte0_next;
            byte1_q <= byte1_next;
            byte2_q <= byte2_next;
        end
    end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_rom_fetch_unit
//
// Directed bench for rom_fetch_unit with DEPTH = 4. The ROM model returns
// ROM[a] = a[7:0] ^ 8'hA5 one cycle after the address is presented.
// ---------------------------------------------------------------------------
module tb_rom_fetch_unit;

    logic        clock;
    logic        reset;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [1:0]  consume;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic [7:0]  byte2;
    logic [2:0]  avail;
    logic [15:0] head_pc;
    logic        consume_err;

    int n_checks = 0;
    int n_pass   = 0;

    rom_fetch_unit #(
        .DEPTH        (4),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .consume     (consume),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .byte0       (byte0),
        .byte1       (byte1),
        .byte2       (byte2),
        .avail       (avail),
        .head_pc     (head_pc),
        .consume_err (consume_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program ROM: registered one-cycle read.
    always @(posedge clock) rom_data <= rom_addr[7:0] ^ 8'hA5;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [7:0]  steady_b0   [4] = '{8'hA1, 8'hA0, 8'hA3, 8'hA2};
    logic [15:0] steady_pc   [4] = '{16'h0004, 16'h0005, 16'h0006, 16'h0007};
    logic [2:0]  steady_av   [4] = '{3'd3, 3'd2, 3'd2, 3'd2};

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        consume   = 2'd0;
        jump_en   = 1'b0;
        jump_addr = 16'h0000;
        rom_data  = 8'h00;
        step();
        step();

        // Reset state
        chk("rst_avail",    32'(avail),       32'd0);
        chk("rst_rom_addr", 32'(rom_addr),    32'h0000);
        chk("rst_head_pc",  32'(head_pc),     32'h0000);
        chk("rst_byte0",    32'(byte0),       32'h00);
        chk("rst_byte1",    32'(byte1),       32'h00);
        chk("rst_byte2",    32'(byte2),       32'h00);
        chk("rst_err",      32'(consume_err), 32'd0);

        // Fill from reset with no consumption
        reset = 1'b0;
        step();
        chk("fill1_addr",  32'(rom_addr), 32'h0001);
        chk("fill1_avail", 32'(avail),    32'd0);
        step();
        chk("fill2_addr",  32'(rom_addr), 32'h0002);
        chk("fill2_avail", 32'(avail),    32'd1);
        chk("fill2_byte0", 32'(byte0),    32'hA5);
        step();
        chk("fill3_addr",  32'(rom_addr), 32'h0003);
        chk("fill3_avail", 32'(avail),    32'd2);
        step();
        chk("fill4_addr",  32'(rom_addr), 32'h0004);
        chk("fill4_avail", 32'(avail),    32'd3);
        step();
        chk("fill5_addr",  32'(rom_addr), 32'h0004);
        chk("fill5_avail", 32'(avail),    32'd4);
        chk("fill5_byte0", 32'(byte0),    32'hA5);
        chk("fill5_byte1", 32'(byte1),    32'hA4);
        chk("fill5_byte2", 32'(byte2),    32'hA7);
        chk("fill5_head",  32'(head_pc),  32'h0000);
        step();
        chk("full_hold_addr",  32'(rom_addr), 32'h0004);
        chk("full_hold_avail", 32'(avail),    32'd4);

        // Full queue: retire three
        consume = 2'd3;
        step();
        chk("pop3_avail", 32'(avail),       32'd1);
        chk("pop3_byte0", 32'(byte0),       32'hA6);
        chk("pop3_byte1", 32'(byte1),       32'h00);
        chk("pop3_head",  32'(head_pc),     32'h0003);
        chk("pop3_addr",  32'(rom_addr),    32'h0004);
        chk("pop3_err",   32'(consume_err), 32'd0);

        // Over-consume with avail = 1 and nothing returning
        consume = 2'd2;
        step();
        chk("err_pulse", 32'(consume_err), 32'd1);
        chk("err_avail", 32'(avail),       32'd1);
        chk("err_byte0", 32'(byte0),       32'hA6);
        chk("err_head",  32'(head_pc),     32'h0003);
        chk("err_addr",  32'(rom_addr),    32'h0005);

        consume = 2'd0;
        step();
        chk("err_clear",   32'(consume_err), 32'd0);
        chk("refill1_av",  32'(avail),       32'd2);
        chk("refill1_b1",  32'(byte1),       32'hA1);
        chk("refill1_adr", 32'(rom_addr),    32'h0006);
        step();
        chk("refill2_av",  32'(avail),       32'd3);
        chk("refill2_adr", 32'(rom_addr),    32'h0007);
        step();
        chk("refill3_av",  32'(avail),       32'd4);
        chk("refill3_adr", 32'(rom_addr),    32'h0007);
        chk("refill3_b2",  32'(byte2),       32'hA0);

        // Steady consumption of one byte per cycle
        consume = 2'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("steady%0d_byte0", i), 32'(byte0),   32'(steady_b0[i]));
            chk($sformatf("steady%0d_head", i),  32'(head_pc), 32'(steady_pc[i]));
            chk($sformatf("steady%0d_avail", i), 32'(avail),   32'(steady_av[i]));
        end

        // Jump with a concurrent consume; a byte is in flight
        jump_en   = 1'b1;
        jump_addr = 16'hFFFE;
        consume   = 2'd2;
        step();
        chk("jmp_avail", 32'(avail),       32'd0);
        chk("jmp_head",  32'(head_pc),     32'hFFFE);
        chk("jmp_addr",  32'(rom_addr),    32'hFFFE);
        chk("jmp_byte0", 32'(byte0),       32'h00);
        chk("jmp_err",   32'(consume_err), 32'd0);

        jump_en = 1'b0;
        consume = 2'd0;
        step();
        chk("jmp1_avail", 32'(avail),    32'd0);
        chk("jmp1_addr",  32'(rom_addr), 32'hFFFF);
        step();
        chk("jmp2_avail", 32'(avail),    32'd1);
        chk("jmp2_byte0", 32'(byte0),    32'h5B);
        chk("jmp2_addr",  32'(rom_addr), 32'h0000);
        step();
        chk("jmp3_avail", 32'(avail),    32'd2);
        chk("jmp3_byte1", 32'(byte1),    32'h5A);
        chk("jmp3_addr",  32'(rom_addr), 32'h0001);
        step();
        chk("jmp4_avail", 32'(avail),    32'd3);
        chk("jmp4_byte2", 32'(byte2),    32'hA5);
        step();
        chk("jmp5_avail", 32'(avail),    32'd4);
        chk("jmp5_addr",  32'(rom_addr), 32'h0002);

        // head_pc wraps FFFE + 2 -> 0000
        consume = 2'd2;
        step();
        chk("wrap_head",  32'(head_pc), 32'h0000);
        chk("wrap_avail", 32'(avail),   32'd2);
        chk("wrap_byte0", 32'(byte0),   32'hA5);
        chk("wrap_byte1", 32'(byte1),   32'hA4);

        // Over-consume while a byte returns: the push still lands
        consume = 2'd1;
        step();
        chk("pre_err_avail", 32'(avail),   32'd1);
        chk("pre_err_byte0", 32'(byte0),   32'hA4);
        chk("pre_err_head",  32'(head_pc), 32'h0001);
        consume = 2'd3;
        step();
        chk("err2_pulse", 32'(consume_err), 32'd1);
        chk("err2_avail", 32'(avail),       32'd2);
        chk("err2_byte0", 32'(byte0),       32'hA4);
        chk("err2_byte1", 32'(byte1),       32'hA7);
        chk("err2_head",  32'(head_pc),     32'h0001);

        // Reset with a byte in flight and a concurrent jump
        consume   = 2'd0;
        reset     = 1'b1;
        jump_en   = 1'b1;
        jump_addr = 16'h1234;
        step();
        chk("mrst_avail", 32'(avail),       32'd0);
        chk("mrst_addr",  32'(rom_addr),    32'h0000);
        chk("mrst_head",  32'(head_pc),     32'h0000);
        chk("mrst_byte0", 32'(byte0),       32'h00);
        chk("mrst_err",   32'(consume_err), 32'd0);

        reset   = 1'b0;
        jump_en = 1'b0;
        step();
        chk("mrst1_avail", 32'(avail),    32'd0);
        chk("mrst1_byte0", 32'(byte0),    32'h00);
        chk("mrst1_addr",  32'(rom_addr), 32'h0001);
        step();
        chk("mrst2_avail", 32'(avail),    32'd1);
        chk("mrst2_byte0", 32'(byte0),    32'hA5);

        // Back-to-back jumps: only the last target is fetched
        jump_en   = 1'b1;
        jump_addr = 16'h1234;
        step();
        chk("bb1_avail", 32'(avail),    32'd0);
        chk("bb1_head",  32'(head_pc),  32'h1234);
        chk("bb1_addr",  32'(rom_addr), 32'h1234);
        jump_addr = 16'h0010;
        step();
        chk("bb2_avail", 32'(avail),    32'd0);
        chk("bb2_head",  32'(head_pc),  32'h0010);
        chk("bb2_addr",  32'(rom_addr), 32'h0010);
        jump_en = 1'b0;
        step();
        chk("bb3_avail", 32'(avail),    32'd0);
        chk("bb3_addr",  32'(rom_addr), 32'h0011);
        step();
        chk("bb4_avail", 32'(avail),    32'd1);
        chk("bb4_byte0", 32'(byte0),    32'hB5);
        chk("bb4_head",  32'(head_pc),  32'h0010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
